// File: rtl/qos_pkg.sv
// Shared definitions for the QoS switch controller: FSM state encoding and width helper.

package qos_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StConfig = 3'd1,
        StAuto   = 3'd2,
        StManual = 3'd3,
        StHold   = 3'd4
    } state_e;

    // Ceiling log2; callers clamp to a minimum of 1 where a zero-width field is illegal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/qos_best_ch_sel.sv
// Combinational search for the valid channel with the lowest error count.
// Ties are broken by priority rank; unlisted channels rank below listed ones, by index.

module qos_best_ch_sel
    import qos_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ERR_W  = 8,
    localparam int CH_W  = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0]       valid,
    input  logic [NUM_CH*ERR_W-1:0] err_count,
    input  logic [NUM_CH*CH_W-1:0]  rank_list,
    output logic                    any_valid,
    output logic [CH_W-1:0]         best_ch,
    output logic [ERR_W-1:0]        best_err
);

    localparam int RANK_W = CH_W + 1;

    logic [RANK_W-1:0] rank [NUM_CH];
    logic [RANK_W-1:0] best_rank;
    logic [ERR_W-1:0]  cand;

    // Scanning ranks downward leaves each channel with its first (best) listing.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            rank[c] = RANK_W'(NUM_CH + c);
            for (int r = NUM_CH - 1; r >= 0; r--) begin
                if (rank_list[r*CH_W +: CH_W] == CH_W'(c)) begin
                    rank[c] = RANK_W'(r);
                end
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        best_ch   = '0;
        best_err  = '0;
        best_rank = '0;
        cand      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (valid[c]) begin
                cand = err_count[c*ERR_W +: ERR_W];
                if (!any_valid || (cand < best_err) ||
                    ((cand == best_err) && (rank[c] < best_rank))) begin
                    any_valid = 1'b1;
                    best_ch   = CH_W'(c);
                    best_err  = cand;
                    best_rank = rank[c];
                end
            end
        end
    end

endmodule

// File: rtl/qos_switch_ctrl.sv
// QoS input switch controller: picks one of NUM_CH transport-stream inputs either by
// manual override or by periodic error-count evaluation with hysteresis and fallback.

module qos_switch_ctrl
    import qos_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int ERR_W   = 8,
    parameter int TIMER_W = 20,
    localparam int CH_W   = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       valid,
    input  logic [NUM_CH*ERR_W-1:0] err_count,
    input  logic                    cfg_valid,
    input  logic                    cfg_manual_en,
    input  logic [CH_W-1:0]         cfg_manual_ch,
    input  logic [NUM_CH*CH_W-1:0]  cfg_priority,
    input  logic                    cfg_fallback_en,
    input  logic [TIMER_W-1:0]      cfg_period,
    input  logic [ERR_W-1:0]        cfg_hyst,
    output logic [CH_W-1:0]         mux_control,
    output logic                    en_mux,
    output logic [TIMER_W-1:0]      timer,
    output logic                    switch_pulse,
    output logic                    no_signal,
    output logic [2:0]              state_o
);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     mux_q, mux_d;
    logic [TIMER_W-1:0]  cnt_q, cnt_d;
    logic                pulse_q;

    logic                man_en_q;
    logic [CH_W-1:0]     man_ch_q;
    logic [NUM_CH*CH_W-1:0] prio_q;
    logic                fb_en_q;
    logic [TIMER_W-1:0]  period_q;
    logic [ERR_W-1:0]    hyst_q;

    logic                any_valid;
    logic [CH_W-1:0]     best_ch;
    logic [ERR_W-1:0]    best_err;
    logic                cur_valid;
    logic [ERR_W-1:0]    cur_err;
    logic [CH_W-1:0]     rank0_ch;
    logic [CH_W-1:0]     manual_sel;
    logic [TIMER_W-1:0]  last_cnt;
    logic                eval;
    logic                better;

    qos_best_ch_sel #(
        .NUM_CH (NUM_CH),
        .ERR_W  (ERR_W)
    ) u_best (
        .valid     (valid),
        .err_count (err_count),
        .rank_list (prio_q),
        .any_valid (any_valid),
        .best_ch   (best_ch),
        .best_err  (best_err)
    );

    always_comb begin
        cur_valid = 1'b0;
        cur_err   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (mux_q == CH_W'(c)) begin
                cur_valid = valid[c];
                cur_err   = err_count[c*ERR_W +: ERR_W];
            end
        end
    end

    // Out-of-range list entries or manual channels fall back to a legal channel.
    assign rank0_ch   = (int'(prio_q[CH_W-1:0]) < NUM_CH) ? prio_q[CH_W-1:0] : '0;
    assign manual_sel = (int'(man_ch_q) < NUM_CH) ? man_ch_q : rank0_ch;

    assign last_cnt = (period_q == '0) ? '0 : period_q - TIMER_W'(1);
    assign eval     = (cnt_q == last_cnt);
    assign better   = ({1'b0, best_err} + {1'b0, hyst_q}) < {1'b0, cur_err};

    always_comb begin
        state_d = state_q;
        mux_d   = mux_q;
        cnt_d   = cnt_q;
        if (cfg_valid) begin
            state_d = StConfig;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: ;
                StConfig: begin
                    cnt_d = '0;
                    if (man_en_q) begin
                        state_d = StManual;
                        mux_d   = manual_sel;
                    end else begin
                        state_d = StAuto;
                        mux_d   = rank0_ch;
                    end
                end
                StAuto: begin
                    if (!any_valid) begin
                        state_d = StHold;
                        cnt_d   = '0;
                    end else if (fb_en_q && !cur_valid) begin
                        // Level-sensitive: any cycle the current input is absent triggers it.
                        mux_d = best_ch;
                        cnt_d = '0;
                    end else if (eval) begin
                        cnt_d = '0;
                        if ((best_ch != mux_q) && (!cur_valid || better)) begin
                            mux_d = best_ch;
                        end
                    end else begin
                        cnt_d = cnt_q + TIMER_W'(1);
                    end
                end
                StHold: begin
                    if (any_valid) begin
                        state_d = StAuto;
                        mux_d   = best_ch;
                        cnt_d   = '0;
                    end
                end
                StManual: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mux_q   <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mux_q   <= mux_d;
            cnt_q   <= cnt_d;
            pulse_q <= (mux_d != mux_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            man_en_q <= 1'b0;
            man_ch_q <= '0;
            prio_q   <= '0;
            fb_en_q  <= 1'b0;
            period_q <= '0;
            hyst_q   <= '0;
        end else if (cfg_valid) begin
            man_en_q <= cfg_manual_en;
            man_ch_q <= cfg_manual_ch;
            prio_q   <= cfg_priority;
            fb_en_q  <= cfg_fallback_en;
            period_q <= cfg_period;
            hyst_q   <= cfg_hyst;
        end
    end

    assign mux_control  = mux_q;
    assign en_mux       = (state_q != StIdle);
    assign timer        = (state_q inside {StAuto, StManual, StHold}) ? period_q : '0;
    assign switch_pulse = pulse_q;
    assign no_signal    = en_mux & ~|valid;
    assign state_o      = state_q;

endmodule

// File: doc/qos_switch_ctrl.md
QOS_SWITCH_CTRL -- requirements
Module: qos_switch_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of TS input channels (legal 2..8).
REQ-002 SHALL have parameter ERR_W, default 8, meaning width of each per-channel error counter.
REQ-003 SHALL have parameter TIMER_W, default 20, meaning width of the evaluation period.
REQ-004 SHALL have derived localparam CH_W = clog2(NUM_CH), minimum 1.
REQ-005 SHALL have port clk  input  1  system clock, rising-edge; the block uses one clock.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port valid  input  NUM_CH  per-channel signal-present flags.
REQ-008 SHALL have port err_count  input  NUM_CH*ERR_W  packed error counters, ch0 in LSBs.
REQ-009 SHALL have port cfg_valid  input  1  one-cycle strobe; captures all cfg_* inputs.
REQ-010 SHALL have port cfg_manual_en  input  1  1 = manual mode, 0 = auto mode.
REQ-011 SHALL have port cfg_manual_ch  input  CH_W  channel forced in manual mode.
REQ-012 SHALL have port cfg_priority  input  NUM_CH*CH_W  priority list, rank 0 (highest) in LSBs.
REQ-013 SHALL have port cfg_fallback_en  input  1  enables immediate switch on loss of valid.
REQ-014 SHALL have port cfg_period  input  TIMER_W  evaluation period in clock cycles.
REQ-015 SHALL have port cfg_hyst  input  ERR_W  hysteresis margin for auto switching.
REQ-016 SHALL have port mux_control  output  CH_W  selected channel.
REQ-017 SHALL have port en_mux  output  1  mux enable, 1 once configured.
REQ-018 SHALL have port timer  output  TIMER_W  captured period; 0 when disabled or in CONFIG.
REQ-019 SHALL have port switch_pulse  output  1  one-cycle pulse on every mux_control change.
REQ-020 SHALL have port no_signal  output  1  1 while all valid bits are 0 and en_mux = 1.
REQ-021 SHALL have port state_o  output  3  current FSM state for status readback.

Function
REQ-022 FSM states SHALL be IDLE, CONFIG, AUTO, MANUAL, HOLD.
REQ-023 IDLE -> CONFIG on cfg_valid; otherwise remain IDLE with en_mux = 0.
REQ-024 cfg_valid in any state SHALL capture cfg_* that cycle and enter CONFIG next cycle; it overrides any same-cycle evaluation or fallback.
REQ-025 CONFIG SHALL last exactly one cycle, set en_mux = 1, clear the period counter, then enter MANUAL if cfg_manual_en else AUTO.
REQ-026 On CONFIG exit, mux_control SHALL become cfg_manual_ch (MANUAL) or priority rank 0 (AUTO); manual_ch >= NUM_CH SHALL select rank 0.
REQ-027 MANUAL SHALL hold mux_control until the next cfg_valid, ignoring valid and err_count.
REQ-028 In AUTO, the period counter SHALL count 0..P-1 with P = max(cfg_period, 1), wrapping to 0; evaluation occurs in the cycle count = P-1.
REQ-029 Evaluation: best = valid channel with minimum error; ties SHALL go to the lower priority rank.
REQ-030 Switch SHALL occur if best != current and (current not valid, or err_best + hyst < err_current), sum computed at ERR_W+1 bits without overflow.
REQ-031 A switch SHALL update mux_control at the clock edge ending the evaluation cycle, with switch_pulse high for the following cycle.
REQ-032 With cfg_fallback_en = 1, if the current channel's valid falls in AUTO, the best valid channel SHALL be selected next edge regardless of counter, and the counter SHALL clear.
REQ-033 If no channel is valid in AUTO, the FSM SHALL enter HOLD, keep mux_control, and assert no_signal.
REQ-034 HOLD -> AUTO on the first cycle any valid bit is 1, selecting the best valid channel with the counter cleared.
REQ-035 Duplicate entries in cfg_priority SHALL be legal; unlisted channels rank below all listed ones, ordered by index.

Reset
REQ-036 On rst_n low, asynchronously: state IDLE, mux_control 0, en_mux 0, timer 0, switch_pulse 0, no_signal 0, counter 0, config registers 0.
REQ-037 Reset mid-operation SHALL abort any pending switch; no switch_pulse SHALL follow reset release.

Structure
REQ-038 Package qos_pkg SHALL hold the FSM state encoding and the clog2 helper.
REQ-039 Sub-module qos_best_ch_sel SHALL implement the combinational valid-masked, rank-tie-broken minimum search, parametrised by NUM_CH, ERR_W.

Verification
REQ-040 NUM_CH=4: cfg_valid with auto, priority {3,2,1,0}, period 10 -> mux_control 0 two cycles later; en_mux 1; timer 10.
REQ-041 err {ch0=20, ch1=5}, hyst 4, all valid -> switch to ch1 at count 9 with one switch_pulse; with hyst 15 -> no switch.
REQ-042 Fallback on, current ch0 valid drops mid-period -> mux_control = best valid next edge, counter 0.
REQ-043 All valid = 0 -> HOLD, no_signal 1; valid[2] = 1 -> AUTO, mux_control 2.
REQ-044 Manual ch3, then cfg_valid coincident with count = P-1 -> CONFIG wins, no evaluation switch.
REQ-045 NUM_CH=8, ERR_W=12: equal errors on ranks 0 and 5 -> rank 0 channel chosen; rst_n pulse mid-period -> all outputs 0.
